// File: rtl/icache_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module : icache_pkg
//  Brief  : Shared constants, state encoding and helpers for the I-cache.
//  Rev    : 1.0  initial release
// ============================================================================
package icache_pkg;

    localparam int LINE_W = 128;
    localparam int WORD_W = 32;
    localparam int BEATS  = 4;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_LOOKUP    = 3'd1,
        ST_MISS_REQ  = 3'd2,
        ST_MISS_FILL = 3'd3,
        ST_RESPOND   = 3'd4
    } state_e;

    // Byte address of the 16-byte line holding pc.
    function automatic logic [31:0] line_addr(input logic [31:0] pc);
        return pc & 32'hFFFF_FFF0;
    endfunction

endpackage
`default_nettype wire

// File: rtl/icache_line_store.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module : icache_line_store
//  Brief  : Direct-mapped tag/valid/data arrays, one comb read, one write port.
//  Rev    : 1.0  initial release
// ============================================================================
module icache_line_store
    import icache_pkg::*;
#(
    parameter int NUM_LINES = 16,
    parameter int IDX_W     = $clog2(NUM_LINES),
    parameter int TAG_W     = 28 - IDX_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [IDX_W-1:0]  rd_idx,
    output logic              rd_valid,
    output logic [TAG_W-1:0]  rd_tag,
    output logic [LINE_W-1:0] rd_data,
    input  logic              wr_en,
    input  logic [IDX_W-1:0]  wr_idx,
    input  logic [TAG_W-1:0]  wr_tag,
    input  logic [LINE_W-1:0] wr_data
);

    logic [NUM_LINES-1:0] valid_q;
    logic [NUM_LINES-1:0] valid_d;
    logic [TAG_W-1:0]     tag_mem  [NUM_LINES];
    logic [LINE_W-1:0]    data_mem [NUM_LINES];

    always_comb begin
        valid_d = valid_q;
        if (wr_en) begin
            valid_d[wr_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
        end
    end

    // Tag and data contents are meaningless until their valid bit is set.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            tag_mem[wr_idx]  <= wr_tag;
            data_mem[wr_idx] <= wr_data;
        end
    end

    assign rd_valid = valid_q[rd_idx];
    assign rd_tag   = tag_mem[rd_idx];
    assign rd_data  = data_mem[rd_idx];

endmodule
`default_nettype wire

// File: rtl/icache_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module : icache_ctrl
//  Brief  : Direct-mapped I-cache controller: lookup, 4-beat refill, respond.
//  Rev    : 1.0  initial release
// ============================================================================
module icache_ctrl
    import icache_pkg::*;
#(
    parameter int NUM_LINES = 16,
    parameter int CNT_W     = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       ifq_pc_in,
    input  logic              ifq_rd_en,
    input  logic              ifq_abort,
    output logic [LINE_W-1:0] ifq_dout,
    output logic              ifq_dout_valid,
    output logic              mem_req,
    output logic [31:0]       mem_addr,
    input  logic              mem_gnt,
    input  logic [WORD_W-1:0] mem_rdata,
    input  logic              mem_rvalid,
    output logic [CNT_W-1:0]  stat_hit_cnt,
    output logic [CNT_W-1:0]  stat_miss_cnt
);

    localparam int IDX_W = $clog2(NUM_LINES);
    localparam int TAG_W = 28 - IDX_W;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_e                        state_q, state_d;
    logic [31:0]                   req_pc_q, req_pc_d;
    logic [BEATS-1:0][WORD_W-1:0]  fill_q, fill_d;
    logic [1:0]                    beat_q, beat_d;
    logic                          aborted_q, aborted_d;
    logic [LINE_W-1:0]             dout_q, dout_d;
    logic [CNT_W-1:0]              hit_cnt_q, hit_cnt_d;
    logic [CNT_W-1:0]              miss_cnt_q, miss_cnt_d;

    logic                          st_rd_valid;
    logic [TAG_W-1:0]              st_rd_tag;
    logic [LINE_W-1:0]             st_rd_data;
    logic                          st_wr_en;
    logic                          lookup_hit;

    assign lookup_hit = st_rd_valid && (st_rd_tag == req_pc_q[31:IDX_W+4]);

    icache_line_store #(
        .NUM_LINES (NUM_LINES)
    ) u_store (
        .clk      (clk),
        .rst      (rst),
        .rd_idx   (req_pc_q[IDX_W+3:4]),
        .rd_valid (st_rd_valid),
        .rd_tag   (st_rd_tag),
        .rd_data  (st_rd_data),
        .wr_en    (st_wr_en),
        .wr_idx   (req_pc_q[IDX_W+3:4]),
        .wr_tag   (req_pc_q[31:IDX_W+4]),
        .wr_data  (fill_d)
    );

    always_comb begin
        state_d    = state_q;
        req_pc_d   = req_pc_q;
        fill_d     = fill_q;
        beat_d     = beat_q;
        aborted_d  = aborted_q;
        dout_d     = dout_q;
        hit_cnt_d  = hit_cnt_q;
        miss_cnt_d = miss_cnt_q;
        st_wr_en   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (ifq_rd_en && !ifq_abort) begin
                    req_pc_d = ifq_pc_in;
                    state_d  = ST_LOOKUP;
                end
            end
            ST_LOOKUP: begin
                if (ifq_abort) begin
                    state_d = ST_IDLE;
                end else if (lookup_hit) begin
                    hit_cnt_d = (hit_cnt_q == '1) ? hit_cnt_q : hit_cnt_q + CNT_ONE;
                    dout_d    = st_rd_data;
                    state_d   = ST_RESPOND;
                end else begin
                    miss_cnt_d = (miss_cnt_q == '1) ? miss_cnt_q : miss_cnt_q + CNT_ONE;
                    state_d    = ST_MISS_REQ;
                end
            end
            ST_MISS_REQ: begin
                if (ifq_abort) begin
                    state_d = ST_IDLE;
                end else if (mem_gnt) begin
                    beat_d    = 2'd0;
                    aborted_d = 1'b0;
                    state_d   = ST_MISS_FILL;
                end
            end
            ST_MISS_FILL: begin
                // The memory always delivers all beats once granted, so an
                // abort only suppresses the response; the line is still kept.
                if (ifq_abort) begin
                    aborted_d = 1'b1;
                end
                if (mem_rvalid) begin
                    fill_d[beat_q] = mem_rdata;
                    beat_d         = beat_q + 2'd1;
                    if (beat_q == 2'd3) begin
                        st_wr_en  = 1'b1;
                        dout_d    = fill_d;
                        aborted_d = 1'b0;
                        state_d   = (aborted_q || ifq_abort) ? ST_IDLE : ST_RESPOND;
                    end
                end
            end
            ST_RESPOND: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            req_pc_q   <= '0;
            fill_q     <= '0;
            beat_q     <= '0;
            aborted_q  <= 1'b0;
            dout_q     <= '0;
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            req_pc_q   <= req_pc_d;
            fill_q     <= fill_d;
            beat_q     <= beat_d;
            aborted_q  <= aborted_d;
            dout_q     <= dout_d;
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

    // A late redirect still kills the strobe in the respond cycle itself.
    assign ifq_dout_valid = (state_q == ST_RESPOND) && !ifq_abort;
    assign ifq_dout       = dout_q;
    assign mem_req        = (state_q == ST_MISS_REQ);
    assign mem_addr       = mem_req ? line_addr(req_pc_q) : 32'h0;
    assign stat_hit_cnt   = hit_cnt_q;
    assign stat_miss_cnt  = miss_cnt_q;

endmodule
`default_nettype wire
